// File: rtl/operand_job_dispatcher.sv
// operand_job_dispatcher
//   Initiator side of a start/done operand interface. Operand sets (six
//   operands each) from a host are queued in a small FIFO. Each set is then
//   presented to the datapath with a one-cycle start pulse. The bench waits
//   for done, captures the result and returns it to the host over a
//   valid/ready channel. A watchdog closes a job whose datapath never
//   answers and flags the result as an error.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   job_valid/job_ready       host push handshake; job_ready = queue not full
//   job_i1..job_i6            operands of the offered job
//   o1..o6                    operands driven to the datapath (held per job)
//   start                     one-cycle launch pulse
//   dut_done/dut_result       datapath completion and its result
//   res_valid/res_ready       result handshake towards the host
//   res_data/res_err          captured result (0 and err=1 on timeout)
//   busy                      a job is in flight (launch, wait or hold)
//   job_count                 jobs queued, not counting the one in flight
module operand_job_dispatcher #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [WIDTH-1:0]         job_i1,
    input  logic [WIDTH-1:0]         job_i2,
    input  logic [WIDTH-1:0]         job_i3,
    input  logic [WIDTH-1:0]         job_i4,
    input  logic [WIDTH-1:0]         job_i5,
    input  logic [WIDTH-1:0]         job_i6,
    output logic [WIDTH-1:0]         o1,
    output logic [WIDTH-1:0]         o2,
    output logic [WIDTH-1:0]         o3,
    output logic [WIDTH-1:0]         o4,
    output logic [WIDTH-1:0]         o5,
    output logic [WIDTH-1:0]         o6,
    output logic                     start,
    input  logic                     dut_done,
    input  logic [WIDTH-1:0]         dut_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic                     res_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   job_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    // Job queue: one entry holds {i6, i5, i4, i3, i2, i1}
    logic [6*WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        count_q;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      tmo_q, tmo_d;
    logic [6*WIDTH-1:0] ops_q, ops_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               res_err_q, res_err_d;

    logic push, pop;

    // A full queue refuses the push outright, even if a pop happens this cycle
    assign job_ready = (count_q != CNT_FULL);
    assign push      = job_valid && job_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {job_i6, job_i5, job_i4, job_i3, job_i2, job_i1};
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        ops_d      = ops_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    ops_d   = mem_q[rd_ptr_q];
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                // done is checked first so a completion in the last allowed
                // cycle still returns a good result
                if (dut_done) begin
                    res_data_d = dut_result;
                    res_err_d  = 1'b0;
                    state_d    = S_HOLD;
                end else if (tmo_q == TMO_LAST) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            tmo_q      <= '0;
            ops_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            ops_q      <= ops_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    // Status decoded straight from the state so reset clears start at once
    assign start     = (state_q == S_LAUNCH);
    assign res_valid = (state_q == S_HOLD);
    assign busy      = (state_q != S_IDLE);
    assign job_count = count_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

    assign o1 = ops_q[0*WIDTH +: WIDTH];
    assign o2 = ops_q[1*WIDTH +: WIDTH];
    assign o3 = ops_q[2*WIDTH +: WIDTH];
    assign o4 = ops_q[3*WIDTH +: WIDTH];
    assign o5 = ops_q[4*WIDTH +: WIDTH];
    assign o6 = ops_q[5*WIDTH +: WIDTH];

endmodule

// File: tb/tb_operand_job_dispatcher.sv
// Bench for operand_job_dispatcher. A responder answers each start pulse
// with done after a per-job delay (0 = never) and result = sum of operands.
// A queue-based reference model predicts every launch, result and latency.
module tb_operand_job_dispatcher;

    localparam int W   = 32;
    localparam int D   = 4;
    localparam int TMO = 16;

    typedef logic [5:0][W-1:0] ops_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic job_valid = 1'b0;
    logic job_ready;
    ops_t job_ops = '0;
    logic [W-1:0] o1, o2, o3, o4, o5, o6;
    ops_t o_vec;
    logic start;
    logic resp_done;
    logic [W-1:0] resp_result;
    logic stray_done = 1'b0;
    logic dut_done;
    logic [W-1:0] dut_result;
    logic res_valid;
    logic res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic res_err;
    logic busy;
    logic [$clog2(D):0] job_count;
    logic [W-1:0] sum_o;

    assign o_vec      = {o6, o5, o4, o3, o2, o1};
    assign sum_o      = o1 + o2 + o3 + o4 + o5 + o6;
    assign dut_done   = resp_done | stray_done;
    assign dut_result = stray_done ? 32'hDEADBEEF : resp_result;

    operand_job_dispatcher #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_i1(job_ops[0]), .job_i2(job_ops[1]), .job_i3(job_ops[2]),
        .job_i4(job_ops[3]), .job_i5(job_ops[4]), .job_i6(job_ops[5]),
        .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6),
        .start(start), .dut_done(dut_done), .dut_result(dut_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err),
        .busy(busy), .job_count(job_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model and observation queues
    int   dly_q[$];
    ops_t exp_launch[$];
    logic [W:0] exp_res[$];
    int   exp_lat[$];
    ops_t got_launch[$];
    logic [W:0] got_res[$];
    int   got_lat[$];

    // Responder: done arrives in the Nth cycle after the start cycle
    int cd;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_done   <= 1'b0;
            resp_result <= '0;
            cd          <= 0;
        end else begin
            resp_done <= 1'b0;
            if (start) begin
                if (dly_q.size() != 0) begin
                    if (dly_q[0] == 1) begin
                        resp_done   <= 1'b1;
                        resp_result <= sum_o;
                    end
                    cd <= (dly_q[0] > 1) ? dly_q[0] - 1 : 0;
                    dly_q.delete(0);
                end else begin
                    cd <= 0;
                end
            end else if (cd > 0) begin
                cd <= cd - 1;
                if (cd == 1) begin
                    resp_done   <= 1'b1;
                    resp_result <= sum_o;
                end
            end
        end
    end

    // Monitor: samples on the falling edge, records launches and results
    int   cyc = 0;
    int   last_start = 0;
    int   start_cnt = 0;
    int   dbl_start = 0;
    int   last_acc_cyc = 0;
    logic prev_start = 1'b0;
    logic prev_rv = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst) begin
            prev_start <= start;
            prev_rv    <= res_valid;
            if (start) begin
                got_launch.push_back(o_vec);
                last_start <= cyc;
                start_cnt  <= start_cnt + 1;
            end
            if (start && prev_start) dbl_start <= dbl_start + 1;
            if (res_valid && !prev_rv) got_lat.push_back(cyc - last_start);
            if (res_valid && res_ready) got_res.push_back({res_err, res_data});
        end else begin
            prev_start <= 1'b0;
            prev_rv    <= 1'b0;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_model();
        dly_q.delete();
        exp_launch.delete(); exp_res.delete(); exp_lat.delete();
        got_launch.delete(); got_res.delete(); got_lat.delete();
    endtask

    function automatic ops_t rand_ops();
        ops_t r;
        for (int k = 0; k < 6; k++) r[k] = $urandom() | 32'h1;
        return r;
    endfunction

    // Predicted outcome of one accepted job from its operands and delay
    task automatic model_accept(input ops_t ops, input int d);
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < 6; k++) s = s + ops[k];
        exp_launch.push_back(ops);
        dly_q.push_back(d);
        if (d == 0 || d > TMO) begin
            exp_res.push_back({1'b1, {W{1'b0}}});
            exp_lat.push_back(TMO + 1);
        end else begin
            exp_res.push_back({1'b0, s});
            exp_lat.push_back(d + 1);
        end
    endtask

    // Offer one job for one cycle; called at the drive point
    task automatic offer(input ops_t ops, input int d, output bit acc);
        job_valid = 1'b1;
        job_ops   = ops;
        @(negedge clk);
        acc = job_ready;
        if (acc) begin
            model_accept(ops, d);
            last_acc_cyc = cyc;
        end
        tick();
        job_valid = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (got_res.size() == exp_res.size() && !busy && job_count == 0) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        n_cmp++; if (start !== 1'b0)     begin n_bad++; $display("FAIL rst_start got %b want 0", start); end
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
        n_cmp++; if (res_err !== 1'b0)   begin n_bad++; $display("FAIL rst_res_err got %b want 0", res_err); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (job_count !== '0)   begin n_bad++; $display("FAIL rst_job_count got %0d want 0", job_count); end
        n_cmp++; if (res_data !== '0)    begin n_bad++; $display("FAIL rst_res_data got %h want 0", res_data); end
        n_cmp++; if (o_vec !== '0)       begin n_bad++; $display("FAIL rst_ops got %h want 0", o_vec); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_cmp++; if (job_ready !== 1'b1) begin n_bad++; $display("FAIL rst_job_ready got %b want 1", job_ready); end
    endtask

    task automatic test_single();
        ops_t ops;
        bit acc, ok;
        int s0;
        clear_model();
        res_ready = 1'b1;
        s0 = start_cnt;
        ops[0] = 32'd2; ops[1] = 32'd3; ops[2] = 32'd4;
        ops[3] = 32'd5; ops[4] = 32'd3; ops[5] = 32'd2;
        offer(ops, 3, acc);
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL t1_accept got %b want 1", acc); end
        drain(50, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t1_drain got timeout want done"); end
        n_cmp++; if (start_cnt - s0 != 1) begin n_bad++; $display("FAIL t1_starts got %0d want 1", start_cnt - s0); end
        n_cmp++; if (last_start - last_acc_cyc < 2) begin n_bad++; $display("FAIL t1_push_to_start got %0d want >=2", last_start - last_acc_cyc); end
        n_cmp++;
        if (got_res.size() < 1) begin n_bad++; $display("FAIL t1_sum got none want 19"); end
        else if (got_res[0] !== {1'b0, 32'd19}) begin n_bad++; $display("FAIL t1_sum got err=%0b data=%0d want err=0 data=19", got_res[0][W], got_res[0][W-1:0]); end
        n_cmp++;
        if (got_res.size() != exp_res.size() || got_launch.size() != exp_launch.size() || got_lat.size() != exp_lat.size()) begin
            n_bad++; $display("FAIL t1_counts got res=%0d launch=%0d lat=%0d want %0d", got_res.size(), got_launch.size(), got_lat.size(), exp_res.size());
        end
        for (int i = 0; i < exp_res.size(); i++) begin
            n_cmp++;
            if (i >= got_res.size() || i >= got_launch.size() || i >= got_lat.size()) begin n_bad++; $display("FAIL t1_job%0d got none want err=%0b data=%h", i, exp_res[i][W], exp_res[i][W-1:0]); end
            else if (got_res[i] !== exp_res[i] || got_launch[i] !== exp_launch[i] || got_lat[i] != exp_lat[i]) begin
                n_bad++; $display("FAIL t1_job%0d got err=%0b data=%h lat=%0d ops=%h want err=%0b data=%h lat=%0d ops=%h", i, got_res[i][W], got_res[i][W-1:0], got_lat[i], got_launch[i], exp_res[i][W], exp_res[i][W-1:0], exp_lat[i], exp_launch[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit acc, ok;
        int n_acc;
        clear_model();
        res_ready = 1'b1;
        n_acc = 0;
        for (int j = 0; j < 5; j++) begin
            offer(rand_ops(), $urandom_range(1, 6), acc);
            if (acc) n_acc++;
        end
        n_cmp++; if (n_acc != 5) begin n_bad++; $display("FAIL t2_accepted got %0d want 5", n_acc); end
        n_cmp++; if (job_count !== 3'd4) begin n_bad++; $display("FAIL t2_job_count got %0d want 4", job_count); end
        n_cmp++; if (job_ready !== 1'b0) begin n_bad++; $display("FAIL t2_full_ready got %b want 0", job_ready); end
        offer(rand_ops(), 1, acc);
        n_cmp++; if (acc !== 1'b0) begin n_bad++; $display("FAIL t2_full_reject got %b want 0", acc); end
        drain(300, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t2_drain got timeout want done"); end
        n_cmp++;
        if (got_res.size() != exp_res.size() || got_launch.size() != exp_launch.size() || got_lat.size() != exp_lat.size()) begin
            n_bad++; $display("FAIL t2_counts got res=%0d launch=%0d lat=%0d want %0d", got_res.size(), got_launch.size(), got_lat.size(), exp_res.size());
        end
        for (int i = 0; i < exp_res.size(); i++) begin
            n_cmp++;
            if (i >= got_res.size() || i >= got_launch.size() || i >= got_lat.size()) begin n_bad++; $display("FAIL t2_job%0d got none want err=%0b data=%h", i, exp_res[i][W], exp_res[i][W-1:0]); end
            else if (got_res[i] !== exp_res[i] || got_launch[i] !== exp_launch[i] || got_lat[i] != exp_lat[i]) begin
                n_bad++; $display("FAIL t2_job%0d got err=%0b data=%h lat=%0d ops=%h want err=%0b data=%h lat=%0d ops=%h", i, got_res[i][W], got_res[i][W-1:0], got_lat[i], got_launch[i], exp_res[i][W], exp_res[i][W-1:0], exp_lat[i], exp_launch[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit acc, ok, seen;
        int n_acc;
        logic [W-1:0] hd;
        logic he;
        ops_t ops;
        clear_model();
        res_ready = 1'b0;
        offer(rand_ops(), 2, acc);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = res_valid;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL t3_res_valid got 0 want 1 within 30 cycles"); end
        hd = res_data;
        he = res_err;
        n_cmp++; if (exp_res.size() < 1 || {he, hd} !== exp_res[0]) begin n_bad++; $display("FAIL t3_hold_value got err=%0b data=%h want first job result", he, hd); end
        tick();
        n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            ops = rand_ops();
            job_valid  = (c < 4);
            job_ops    = ops;
            stray_done = (c == 5);
            @(negedge clk);
            n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL t3_valid_c%0d got %b want 1", c, res_valid); end
            n_cmp++; if (res_data !== hd || res_err !== he) begin n_bad++; $display("FAIL t3_data_c%0d got err=%0b data=%h want err=%0b data=%h", c, res_err, res_data, he, hd); end
            n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL t3_start_c%0d got %b want 0", c, start); end
            if (job_valid && job_ready) begin
                model_accept(ops, $urandom_range(1, 8));
                n_acc++;
            end
            tick();
        end
        job_valid  = 1'b0;
        stray_done = 1'b0;
        n_cmp++; if (n_acc != 4) begin n_bad++; $display("FAIL t3_accepted got %0d want 4", n_acc); end
        n_cmp++; if (job_count !== 3'd4 || job_ready !== 1'b0) begin n_bad++; $display("FAIL t3_queue got count=%0d ready=%b want count=4 ready=0", job_count, job_ready); end
        res_ready = 1'b1;
        drain(300, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t3_drain got timeout want done"); end
        n_cmp++;
        if (got_res.size() != exp_res.size() || got_launch.size() != exp_launch.size() || got_lat.size() != exp_lat.size()) begin
            n_bad++; $display("FAIL t3_counts got res=%0d launch=%0d lat=%0d want %0d", got_res.size(), got_launch.size(), got_lat.size(), exp_res.size());
        end
        for (int i = 0; i < exp_res.size(); i++) begin
            n_cmp++;
            if (i >= got_res.size() || i >= got_launch.size() || i >= got_lat.size()) begin n_bad++; $display("FAIL t3_job%0d got none want err=%0b data=%h", i, exp_res[i][W], exp_res[i][W-1:0]); end
            else if (got_res[i] !== exp_res[i] || got_launch[i] !== exp_launch[i] || got_lat[i] != exp_lat[i]) begin
                n_bad++; $display("FAIL t3_job%0d got err=%0b data=%h lat=%0d ops=%h want err=%0b data=%h lat=%0d ops=%h", i, got_res[i][W], got_res[i][W-1:0], got_lat[i], got_launch[i], exp_res[i][W], exp_res[i][W-1:0], exp_lat[i], exp_launch[i]);
            end
        end
    endtask

    // Silent responder, then a normal job behind it; plus done on the
    // boundary cycles 15, 16 and 17 of the wait window
    task automatic test_timeout_and_done_wins();
        bit acc, ok;
        int dl[6];
        dl = '{0, 5, 15, 16, 17, 1};
        clear_model();
        res_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            offer(rand_ops(), dl[j], acc);
            n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL t45_accept%0d got %b want 1", j, acc); end
            if (j == 1) begin
                drain(100, ok);
                n_cmp++; if (!ok) begin n_bad++; $display("FAIL t4_drain got timeout want done"); end
            end
        end
        drain(300, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t5_drain got timeout want done"); end
        n_cmp++;
        if (got_res.size() < 1) begin n_bad++; $display("FAIL t4_timeout got none want err=1 data=0"); end
        else if (got_res[0] !== {1'b1, 32'd0} || got_lat.size() < 1 || got_lat[0] != TMO + 1) begin
            n_bad++; $display("FAIL t4_timeout got err=%0b data=%h want err=1 data=0 after %0d cycles", got_res[0][W], got_res[0][W-1:0], TMO + 1);
        end
        n_cmp++;
        if (got_res.size() != exp_res.size() || got_launch.size() != exp_launch.size() || got_lat.size() != exp_lat.size()) begin
            n_bad++; $display("FAIL t45_counts got res=%0d launch=%0d lat=%0d want %0d", got_res.size(), got_launch.size(), got_lat.size(), exp_res.size());
        end
        for (int i = 0; i < exp_res.size(); i++) begin
            n_cmp++;
            if (i >= got_res.size() || i >= got_launch.size() || i >= got_lat.size()) begin n_bad++; $display("FAIL t45_job%0d got none want err=%0b data=%h", i, exp_res[i][W], exp_res[i][W-1:0]); end
            else if (got_res[i] !== exp_res[i] || got_launch[i] !== exp_launch[i] || got_lat[i] != exp_lat[i]) begin
                n_bad++; $display("FAIL t45_job%0d got err=%0b data=%h lat=%0d ops=%h want err=%0b data=%h lat=%0d ops=%h", i, got_res[i][W], got_res[i][W-1:0], got_lat[i], got_launch[i], exp_res[i][W], exp_res[i][W-1:0], exp_lat[i], exp_launch[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int pushed, budget;
        ops_t ops;
        clear_model();
        pushed = 0;
        budget = 0;
        while (pushed < 24 && budget < 3000) begin
            ops       = rand_ops();
            job_valid = ($urandom_range(0, 2) != 0);
            job_ops   = ops;
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (job_valid && job_ready) begin
                model_accept(ops, $urandom_range(0, 19));
                pushed++;
            end
            tick();
            budget++;
        end
        job_valid = 1'b0;
        res_ready = 1'b1;
        n_cmp++; if (pushed != 24) begin n_bad++; $display("FAIL rnd_pushed got %0d want 24", pushed); end
        drain(1500, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd_drain got timeout want done"); end
        n_cmp++; if (dbl_start != 0) begin n_bad++; $display("FAIL rnd_start_width got %0d long pulses want 0", dbl_start); end
        n_cmp++;
        if (got_res.size() != exp_res.size() || got_launch.size() != exp_launch.size() || got_lat.size() != exp_lat.size()) begin
            n_bad++; $display("FAIL rnd_counts got res=%0d launch=%0d lat=%0d want %0d", got_res.size(), got_launch.size(), got_lat.size(), exp_res.size());
        end
        for (int i = 0; i < exp_res.size(); i++) begin
            n_cmp++;
            if (i >= got_res.size() || i >= got_launch.size() || i >= got_lat.size()) begin n_bad++; $display("FAIL rnd_job%0d got none want err=%0b data=%h", i, exp_res[i][W], exp_res[i][W-1:0]); end
            else if (got_res[i] !== exp_res[i] || got_launch[i] !== exp_launch[i] || got_lat[i] != exp_lat[i]) begin
                n_bad++; $display("FAIL rnd_job%0d got err=%0b data=%h lat=%0d ops=%h want err=%0b data=%h lat=%0d ops=%h", i, got_res[i][W], got_res[i][W-1:0], got_lat[i], got_launch[i], exp_res[i][W], exp_res[i][W-1:0], exp_lat[i], exp_launch[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        bit acc, ok, seen;
        int s0;
        clear_model();
        res_ready = 1'b1;
        for (int j = 0; j < 3; j++) offer(rand_ops(), 0, acc);
        n_cmp++; if (job_count !== 3'd2 || busy !== 1'b1) begin n_bad++; $display("FAIL t6_pre got count=%0d busy=%b want count=2 busy=1", job_count, busy); end
        rst = 1'b0;
        #1;
        n_cmp++; if (start !== 1'b0)     begin n_bad++; $display("FAIL t6_start got %b want 0", start); end
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL t6_res_valid got %b want 0", res_valid); end
        n_cmp++; if (job_count !== '0)   begin n_bad++; $display("FAIL t6_job_count got %0d want 0", job_count); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL t6_busy got %b want 0", busy); end
        n_cmp++; if (o_vec !== '0 || res_data !== '0 || res_err !== 1'b0) begin n_bad++; $display("FAIL t6_data got ops=%h data=%h err=%b want all 0", o_vec, res_data, res_err); end
        @(negedge clk);
        clear_model();
        rst = 1'b1;
        tick();
        n_cmp++; if (job_ready !== 1'b1) begin n_bad++; $display("FAIL t6_job_ready got %b want 1", job_ready); end
        s0 = start_cnt;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++; if (start_cnt != s0) begin n_bad++; $display("FAIL t6_stale_start got %0d starts want 0", start_cnt - s0); end

        // reset asserted while start is high must drop it without a clock
        offer(rand_ops(), 0, acc);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = start;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL t6_launch got no start want start"); end
        rst = 1'b0;
        #1;
        n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL t6_start_async got %b want 0", start); end
        @(negedge clk);
        clear_model();
        rst = 1'b1;
        tick();

        offer(rand_ops(), 2, acc);
        drain(50, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t6_drain got timeout want done"); end
        n_cmp++;
        if (got_res.size() != exp_res.size() || got_launch.size() != exp_launch.size() || got_lat.size() != exp_lat.size()) begin
            n_bad++; $display("FAIL t6_counts got res=%0d launch=%0d lat=%0d want %0d", got_res.size(), got_launch.size(), got_lat.size(), exp_res.size());
        end
        for (int i = 0; i < exp_res.size(); i++) begin
            n_cmp++;
            if (i >= got_res.size() || i >= got_launch.size() || i >= got_lat.size()) begin n_bad++; $display("FAIL t6_job%0d got none want err=%0b data=%h", i, exp_res[i][W], exp_res[i][W-1:0]); end
            else if (got_res[i] !== exp_res[i] || got_launch[i] !== exp_launch[i] || got_lat[i] != exp_lat[i]) begin
                n_bad++; $display("FAIL t6_job%0d got err=%0b data=%h lat=%0d ops=%h want err=%0b data=%h lat=%0d ops=%h", i, got_res[i][W], got_res[i][W-1:0], got_lat[i], got_launch[i], exp_res[i][W], exp_res[i][W-1:0], exp_lat[i], exp_launch[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_timeout_and_done_wins();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
